me_search_ctrl: RTL and testbench

ME_SEARCH_CTRL -- requirements
Module: me_search_ctrl

---
 rtl/me_search_ctrl.sv | 138 +++++++++++++
 tb/tb_me_search_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/me_search_ctrl.sv
// me_search_ctrl: full-search motion estimation controller that loads a block, sweeps (2R+1)^2 candidates in raster order
// and keeps the strictly smallest saturating SAD and its motion vector.
module me_search_ctrl #(
    parameter int BLK = 4,
    parameter int R   = 2,
    parameter int SW  = 16,
    parameter int DW  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 crt_keep,
    output logic                 load_req,
    input  logic                 row_vld,
    input  logic [SW-1:0]        row_sad,
    input  logic                 sad_vld,
    output logic signed [DW-1:0] cand_dx,
    output logic signed [DW-1:0] cand_dy,
    output logic signed [DW-1:0] best_dx,
    output logic signed [DW-1:0] best_dy,
    output logic [SW-1:0]        best_sad
);
    localparam int CW = $clog2(BLK + 1);
    localparam logic signed [DW-1:0] RMIN = DW'(-R);
    localparam logic signed [DW-1:0] RMAX = DW'(R);

    typedef enum logic [1:0] {IDLE, LOAD, SEARCH, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         acc_q, acc_d, min_q, min_d, best_sad_q, best_sad_d;
    logic signed [DW-1:0]  dx_q, dx_d, dy_q, dy_d, mdx_q, mdx_d, mdy_q, mdy_d;
    logic signed [DW-1:0]  best_dx_q, best_dx_d, best_dy_q, best_dy_d;
    logic [SW:0]           sum;
    logic [SW-1:0]         csad;
    logic                  last_row, better;

    assign sum      = {1'b0, acc_q} + {1'b0, row_sad};
    assign csad     = sum[SW] ? '1 : sum[SW-1:0];
    assign last_row = cnt_q == CW'(BLK - 1);
    assign better   = csad < min_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        min_d      = min_q;
        mdx_d      = mdx_q;
        mdy_d      = mdy_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        best_dx_d  = best_dx_q;
        best_dy_d  = best_dy_q;
        best_sad_d = best_sad_q;
        case (state_q)
            IDLE: state_d = start ? LOAD : IDLE;
            LOAD: if (row_vld) begin
                if (last_row) begin
                    state_d = SEARCH;
                    cnt_d   = '0;
                    acc_d   = '0;
                    min_d   = '1;
                    mdx_d   = RMIN;
                    mdy_d   = RMIN;
                    dx_d    = RMIN;
                    dy_d    = RMIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SEARCH: if (sad_vld) begin
                if (!last_row) begin
                    acc_d = csad;
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    acc_d = '0;
                    cnt_d = '0;
                    min_d = better ? csad : min_q;
                    mdx_d = better ? dx_q : mdx_q;
                    mdy_d = better ? dy_q : mdy_q;
                    dx_d  = (dx_q == RMAX) ? RMIN : dx_q + DW'(1);
                    if (dx_q == RMAX) begin
                        if (dy_q == RMAX) begin
                            // last candidate folds into the result on the same edge
                            state_d    = DONE;
                            best_sad_d = min_d;
                            best_dx_d  = mdx_d;
                            best_dy_d  = mdy_d;
                        end else begin
                            dy_d = dy_q + DW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            min_q      <= '0;
            mdx_q      <= '0;
            mdy_q      <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            best_dx_q  <= '0;
            best_dy_q  <= '0;
            best_sad_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            min_q      <= min_d;
            mdx_q      <= mdx_d;
            mdy_q      <= mdy_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            best_dx_q  <= best_dx_d;
            best_dy_q  <= best_dy_d;
            best_sad_q <= best_sad_d;
        end
    end

    assign busy     = (state_q == LOAD) || (state_q == SEARCH);
    assign done     = state_q == DONE;
    assign crt_keep = state_q == SEARCH;
    assign load_req = state_q == LOAD;
    assign cand_dx  = dx_q;
    assign cand_dy  = dy_q;
    assign best_dx  = best_dx_q;
    assign best_dy  = best_dy_q;
    assign best_sad = best_sad_q;
endmodule

// File: tb/tb_me_search_ctrl.sv
// tb_me_search_ctrl: randomized bench comparing the search controller against a candidate-table reference model.
module tb_me_search_ctrl;
    localparam int BLK  = 4;
    localparam int R    = 2;
    localparam int SW   = 16;
    localparam int DW   = 4;
    localparam int NS   = 2 * R + 1;
    localparam int NC   = NS * NS;
    localparam int MAXS = (1 << SW) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 row_vld = 1'b0;
    logic                 sad_vld = 1'b0;
    logic [SW-1:0]        row_sad = '0;
    logic                 busy, done, crt_keep, load_req;
    logic signed [DW-1:0] cand_dx, cand_dy, best_dx, best_dy;
    logic [SW-1:0]        best_sad;

    int checks = 0;
    int failures = 0;
    int vals [NC][BLK];

    me_search_ctrl #(.BLK(BLK), .R(R), .SW(SW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .crt_keep(crt_keep), .load_req(load_req), .row_vld(row_vld),
        .row_sad(row_sad), .sad_vld(sad_vld), .cand_dx(cand_dx), .cand_dy(cand_dy),
        .best_dx(best_dx), .best_dy(best_dy), .best_sad(best_sad)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: unique min at (1,-1); 1: all ties; 2: all saturate; 3: small random; 4: large random
    task automatic run_search(input int mode, input bit stall);
        int bk, bs, s, cyc, rows;
        bit v;
        for (int k = 0; k < NC; k++)
            for (int r = 0; r < BLK; r++)
                case (mode)
                    0: vals[k][r] = (k % NS - R == 1 && k / NS - R == -1) ? 1 : 10;
                    1: vals[k][r] = 5;
                    2: vals[k][r] = 'hF000;
                    3: vals[k][r] = int'($urandom_range(0, 60));
                    default: vals[k][r] = int'($urandom_range(0, MAXS));
                endcase
        bk = 0;
        bs = MAXS;
        for (int k = 0; k < NC; k++) begin
            s = 0;
            for (int r = 0; r < BLK; r++) s = (s + vals[k][r] > MAXS) ? MAXS : s + vals[k][r];
            if (s < bs) begin
                bs = s;
                bk = k;
            end
        end
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        chk("busy_load", int'(busy), 1);
        chk("load_req", int'(load_req), 1);
        rows = 0;
        while (rows < BLK) begin
            row_vld = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            sad_vld = stall ? 1'($urandom_range(0, 1)) : 1'b0;
            row_sad = SW'($urandom);
            step();
            cyc++;
            if (row_vld) rows++;
            if (rows < BLK) chk("keep_load", int'(crt_keep), 0);
        end
        row_vld = 1'b0;
        chk("keep_search", int'(crt_keep), 1);
        chk("load_req_off", int'(load_req), 0);
        for (int k = 0; k < NC; k++)
            for (int r = 0; r < BLK; r++) begin
                v = 1'b0;
                while (!v) begin
                    v = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                    sad_vld = v;
                    row_sad = v ? SW'(vals[k][r]) : SW'($urandom);
                    start   = stall && ($urandom_range(0, 7) == 0);
                    row_vld = stall ? 1'($urandom_range(0, 1)) : 1'b0;
                    chk("cand_dx", int'(cand_dx), k % NS - R);
                    chk("cand_dy", int'(cand_dy), k / NS - R);
                    chk("keep_search", int'(crt_keep), 1);
                    chk("done_early", int'(done), 0);
                    step();
                    cyc++;
                end
            end
        sad_vld = 1'b0;
        row_vld = 1'b0;
        start   = stall;
        chk("done", int'(done), 1);
        chk("busy_done", int'(busy), 0);
        chk("keep_done", int'(crt_keep), 0);
        chk("best_dx", int'(best_dx), bk % NS - R);
        chk("best_dy", int'(best_dy), bk / NS - R);
        chk("best_sad", int'(best_sad), bs);
        if (!stall) chk("latency", cyc, 1 + BLK + BLK * NC);
        step();
        start = 1'b0;
        chk("done_pulse", int'(done), 0);
        step();
        chk("no_restart", int'(busy), 0);
        chk("best_sad_hold", int'(best_sad), bs);
    endtask

    initial begin
        step();
        step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_best_sad", int'(best_sad), 0);
        chk("rst_cand_dx", int'(cand_dx), 0);
        rst = 1'b0;
        run_search(0, 1'b0);
        run_search(1, 1'b0);
        run_search(2, 1'b0);
        run_search(0, 1'b1);
        for (int i = 0; i < 3; i++) run_search(3, 1'b1);
        for (int i = 0; i < 3; i++) run_search(4, i[0]);
        start = 1'b1;
        step();
        start = 1'b0;
        row_vld = 1'b1;
        repeat (BLK) step();
        row_vld = 1'b0;
        sad_vld = 1'b1;
        row_sad = 7;
        repeat (30) step();
        rst = 1'b1;
        repeat (2) step();
        sad_vld = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_keep", int'(crt_keep), 0);
        chk("midrst_best_sad", int'(best_sad), 0);
        chk("midrst_cand_dx", int'(cand_dx), 0);
        chk("midrst_cand_dy", int'(cand_dy), 0);
        chk("midrst_done", int'(done), 0);
        rst = 1'b0;
        run_search(0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
